// File: rtl/seq_step_sched_pkg.sv
// Shared constants for the two-requester step scheduler and its modulo-4 sequence engine.
package seq_step_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] S_00 = 2'd0;
  localparam logic [1:0] S_01 = 2'd1;
  localparam logic [1:0] S_10 = 2'd2;
  localparam logic [1:0] S_11 = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/seq_step_sched_engine.sv
// Registered modulo-4 up/down sequence engine; y flags the engine sitting in state 3.
module seq_engine
  import seq_step_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] state,
  output logic       y
);

  logic [1:0] state_nxt;
  logic       dn;

  assign dn = (dir == DIR_DN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_00:    state_nxt = dn ? S_11 : S_01;
      S_01:    state_nxt = dn ? S_00 : S_10;
      S_10:    state_nxt = dn ? S_01 : S_11;
      default: state_nxt = dn ? S_10 : S_00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_00;
    end else if (clr) begin
      state <= S_00;
    end else if (step) begin
      state <= state_nxt;
    end
  end

  assign y = (state == S_11);

endmodule

// File: rtl/seq_step_sched.sv
// Round-robin scheduler sharing one sequence engine between two requesters.
//   state   | meaning
//   IDLE    | no job; arbitrate pending requests, clear engine on grant
//   RUN     | engine steps once per cycle, remaining count decrements
//   DONE    | last step taken; next cycle pulses done_o with the hit count
module seq_step_sched
  import seq_step_sched_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int HIT_W = LEN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [1:0]       dir_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic [1:0]       done_o,
  output logic [HIT_W-1:0] hits_o,
  output logic [1:0]       eng_state_o
);

  logic [1:0]       fsm_q;
  logic             win_q;
  logic             last_q;
  logic             dir_q;
  logic [LEN_W-1:0] rem_q;
  logic [HIT_W-1:0] hit_q;
  logic             step_d;

  logic             win_nxt;
  logic [LEN_W-1:0] len_sel;
  logic             abort;
  logic             eng_clr;
  logic             eng_step;
  logic             eng_y;
  logic             hit_inc;
  logic [HIT_W-1:0] hits_final;

  // Contention goes to whoever was not served last.
  assign win_nxt  = (req_i == 2'b11) ? ~last_q : req_i[1];
  assign len_sel  = win_nxt ? len1_i : len0_i;
  assign abort    = (fsm_q == ST_RUN) && !req_i[win_q];
  assign eng_clr  = (fsm_q == ST_IDLE) && (|req_i);
  assign eng_step = (fsm_q == ST_RUN) && !abort;

  // The engine state after a step is only visible a cycle later, so the hit is
  // credited then; the DONE cycle folds in the credit from the final step.
  assign hit_inc    = step_d && eng_y;
  assign hits_final = hit_q + HIT_W'(hit_inc);

  seq_engine u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (eng_clr),
    .step  (eng_step),
    .dir   (dir_q),
    .state (eng_state_o),
    .y     (eng_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= ST_IDLE;
      win_q  <= 1'b0;
      last_q <= 1'b1;
      dir_q  <= DIR_UP;
      rem_q  <= '0;
      hit_q  <= '0;
      step_d <= 1'b0;
      done_o <= 2'b00;
      hits_o <= '0;
    end else begin
      done_o <= 2'b00;
      step_d <= eng_step;
      case (fsm_q)
        ST_IDLE: begin
          if (|req_i) begin
            win_q <= win_nxt;
            dir_q <= dir_i[win_nxt];
            rem_q <= len_sel;
            hit_q <= '0;
            fsm_q <= (len_sel == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            last_q <= win_q;
            fsm_q  <= ST_IDLE;
          end else begin
            rem_q <= rem_q - LEN_W'(1);
            hit_q <= hits_final;
            if (rem_q == LEN_W'(1)) begin
              fsm_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_o <= onehot2(win_q);
          hits_o <= hits_final;
          last_q <= win_q;
          fsm_q  <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign gnt_o  = busy_o ? onehot2(win_q) : 2'b00;

endmodule
